io_arbiter: RTL and testbench

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_arbiter.sv | 152 +++++++++++++++
 tb/tb_io_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// io_arbiter: four-port round-robin arbiter that captures one port datum at a
// time and holds it for a CPU until acknowledged.
// Optional feature macro: IO_ARB_TIMEOUT_EN (HOLD timeout with sticky err flag).
// Without the macro, err is tied low and HOLD waits indefinitely for cpu_ack.

module io_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] cpu_data,
    output logic [1:0]       cpu_port,
    output logic             cpu_valid,
    input  logic             cpu_ack,
    output logic             err
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       port_q, port_d;
    logic [1:0]       last_q, last_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] win_data;

`ifdef IO_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    // TIMEOUT only matters when the timeout feature is built in.
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    // Round-robin search starting one past the most recently granted port.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winning port's datum.
    always_comb begin
        win_data = '0;
        unique case (win_idx)
            2'd0: win_data = din0;
            2'd1: win_data = din1;
            2'd2: win_data = din2;
            2'd3: win_data = din3;
            default: win_data = '0;
        endcase
    end

    // Next-state logic for the IDLE/HOLD FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        data_d  = data_q;
        port_d  = port_q;
        last_d  = last_q;
`ifdef IO_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StHold;
                    gnt_d   = 4'b0001 << win_idx;
                    data_d  = win_data;
                    port_d  = win_idx;
`ifdef IO_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StHold: begin
                // Ack wins over a timeout landing on the same edge.
                if (cpu_ack) begin
                    state_d = StIdle;
                    last_d  = port_q;
                end
`ifdef IO_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    last_d  = port_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset overrides ack and timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            data_q  <= '0;
            port_q  <= '0;
            last_q  <= 2'd3;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            port_q  <= port_d;
            last_q  <= last_d;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign cpu_data  = data_q;
    assign cpu_port  = port_q;
    assign cpu_valid = (state_q == StHold);
`ifdef IO_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_io_arbiter.sv
// Directed self-checking bench for io_arbiter. Build with IO_ARB_TIMEOUT_EN
// defined to exercise the timeout path (DUT instantiated with TIMEOUT=4).

module tb_io_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic [3:0] gnt;
    logic [7:0] cpu_data;
    logic [1:0] cpu_port;
    logic       cpu_valid;
    logic       cpu_ack;
    logic       err;

    int nvec = 0;
    int nmis = 0;

    io_arbiter #(
        .WIDTH   (8),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .gnt       (gnt),
        .cpu_data  (cpu_data),
        .cpu_port  (cpu_port),
        .cpu_valid (cpu_valid),
        .cpu_ack   (cpu_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b0000; cpu_ack = 1'b0;
        din0 = 8'h00; din1 = 8'h11; din2 = 8'h22; din3 = 8'h33;
        tick(); tick();
        nvec++;
        if ({gnt, cpu_valid, cpu_data, cpu_port, err} !== 16'h0000) begin
            nmis++;
            $display("FAIL reset_state: got gnt=%b valid=%b data=%h port=%0d err=%b, want all 0",
                     gnt, cpu_valid, cpu_data, cpu_port, err);
        end
        reset = 1'b1;
        cpu_ack = 1'b1;  // ack in IDLE must be ignored
        tick();
        nvec++;
        if (cpu_valid !== 1'b0 || gnt !== 4'b0000) begin
            nmis++;
            $display("FAIL idle_ack_ignored: got valid=%b gnt=%b, want 0/0000", cpu_valid, gnt);
        end
        cpu_ack = 1'b0;
    endtask

    task automatic test_single();
        din0 = 8'hA5; req = 4'b0001;
        tick();
        req = 4'b0000;
        nvec++;
        if (gnt !== 4'b0001 || cpu_valid !== 1'b1 || cpu_data !== 8'hA5 || cpu_port !== 2'd0) begin
            nmis++;
            $display("FAIL single_grant: got gnt=%b valid=%b data=%h port=%0d, want 0001/1/a5/0",
                     gnt, cpu_valid, cpu_data, cpu_port);
        end
        tick();
        nvec++;
        if (gnt !== 4'b0000 || cpu_valid !== 1'b1 || cpu_data !== 8'hA5) begin
            nmis++;
            $display("FAIL single_hold: got gnt=%b valid=%b data=%h, want 0000/1/a5",
                     gnt, cpu_valid, cpu_data);
        end
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        nvec++;
        if (cpu_valid !== 1'b0 || gnt !== 4'b0000) begin
            nmis++;
            $display("FAIL single_ack: got valid=%b gnt=%b, want 0/0000", cpu_valid, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_port [5];
        exp_port = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset = 1'b0; tick(); reset = 1'b1;  // last back to 3
        req = 4'b1111; cpu_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (cpu_valid !== 1'b1 || cpu_port !== exp_port[i] ||
                gnt !== (4'b0001 << exp_port[i])) begin
                nmis++;
                $display("FAIL rr_grant[%0d]: got valid=%b port=%0d gnt=%b, want 1/%0d/%b", i,
                         cpu_valid, cpu_port, gnt, exp_port[i], 4'b0001 << exp_port[i]);
            end
            tick();
            nvec++;
            if (cpu_valid !== 1'b0 || gnt !== 4'b0000) begin
                nmis++;
                $display("FAIL rr_idle_gap[%0d]: got valid=%b gnt=%b, want 0/0000",
                         i, cpu_valid, gnt);
            end
        end
        req = 4'b0000; cpu_ack = 1'b0;
        tick();
    endtask

    task automatic test_hold_stable();
        int bad = 0;
        din2 = 8'h3C; req = 4'b0100;  // last=0, so port 2 wins
        tick();
        nvec++;
        if (gnt !== 4'b0100 || cpu_data !== 8'h3C || cpu_port !== 2'd2) begin
            nmis++;
            $display("FAIL hold_enter: got gnt=%b data=%h port=%0d, want 0100/3c/2",
                     gnt, cpu_data, cpu_port);
        end
        din2 = 8'hFF; req = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_data !== 8'h3C || cpu_port !== 2'd2 || gnt !== 4'b0000 || cpu_valid !== 1'b1)
                bad++;
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL hold_stable: got %0d bad cycles (data=%h port=%0d gnt=%b), want 0",
                     bad, cpu_data, cpu_port, gnt);
        end
        cpu_ack = 1'b1; req = 4'b0000;
        tick();
        cpu_ack = 1'b0;
        nvec++;
        if (cpu_valid !== 1'b0) begin
            nmis++;
            $display("FAIL hold_release: got valid=%b, want 0", cpu_valid);
        end
    endtask

    task automatic test_reset_in_hold();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        reset = 1'b0; cpu_ack = 1'b1;
        tick();
        reset = 1'b1; cpu_ack = 1'b0;
        nvec++;
        if ({gnt, cpu_valid, cpu_data, cpu_port, err} !== 16'h0000) begin
            nmis++;
            $display("FAIL reset_in_hold: got gnt=%b valid=%b data=%h port=%0d err=%b, want all 0",
                     gnt, cpu_valid, cpu_data, cpu_port, err);
        end
        req = 4'b1001;  // last=3 must favour port 0
        tick();
        req = 4'b0000;
        nvec++;
        if (cpu_port !== 2'd0 || gnt !== 4'b0001) begin
            nmis++;
            $display("FAIL reset_last: got port=%0d gnt=%b, want 0/0001", cpu_port, gnt);
        end
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        din3 = 8'h5A; req = 4'b1000;
        tick();
        req = 4'b0000;
        nvec++;
        if (cpu_port !== 2'd3 || gnt !== 4'b1000 || cpu_data !== 8'h5A) begin
            nmis++;
            $display("FAIL reset_then_p3: got port=%0d gnt=%b data=%h, want 3/1000/5a",
                     cpu_port, gnt, cpu_data);
        end
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    endtask

`ifdef IO_ARB_TIMEOUT_EN
    task automatic test_timeout();
        reset = 1'b0; tick(); reset = 1'b1;
        req = 4'b0001;
        tick();  // HOLD cycle 1
        req = 4'b0000;
        tick(); tick(); tick();  // HOLD cycles 2..4
        nvec++;
        if (cpu_valid !== 1'b1 || err !== 1'b0) begin
            nmis++;
            $display("FAIL to_pending: got valid=%b err=%b, want 1/0", cpu_valid, err);
        end
        tick();
        nvec++;
        if (cpu_valid !== 1'b0 || err !== 1'b1) begin
            nmis++;
            $display("FAIL to_fire: got valid=%b err=%b, want 0/1", cpu_valid, err);
        end
        req = 4'b1111;  // last updated to 0, so port 1 next
        tick();
        req = 4'b0000;
        nvec++;
        if (cpu_port !== 2'd1 || err !== 1'b1) begin
            nmis++;
            $display("FAIL to_last: got port=%0d err=%b, want 1/1", cpu_port, err);
        end
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        nvec++;
        if (err !== 1'b1 || cpu_valid !== 1'b0) begin
            nmis++;
            $display("FAIL to_sticky: got err=%b valid=%b, want 1/0", err, cpu_valid);
        end
        reset = 1'b0; tick(); reset = 1'b1;
        nvec++;
        if (err !== 1'b0) begin
            nmis++;
            $display("FAIL to_reset_clear: got err=%b, want 0", err);
        end
    endtask

    task automatic test_ack_on_timeout();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick(); tick(); tick();
        cpu_ack = 1'b1;  // lands on the timeout edge
        tick();
        cpu_ack = 1'b0;
        nvec++;
        if (cpu_valid !== 1'b0 || err !== 1'b0) begin
            nmis++;
            $display("FAIL ack_on_timeout: got valid=%b err=%b, want 0/0", cpu_valid, err);
        end
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cpu_valid !== 1'b1 || err !== 1'b0) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL no_timeout: got %0d cycles with valid!=1 or err!=0, want 0", bad);
        end
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        nvec++;
        if (cpu_valid !== 1'b0 || err !== 1'b0) begin
            nmis++;
            $display("FAIL no_timeout_ack: got valid=%b err=%b, want 0/0", cpu_valid, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_stable();
        test_reset_in_hold();
`ifdef IO_ARB_TIMEOUT_EN
        test_timeout();
        test_ack_on_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
